// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: front-end stall, flush and redirect sequencing for branch mispredicts and exceptions.
// Define PIPELINE_CTRL_PERF_EN to add the stall_cycles / flush_events performance counters.
module pipeline_ctrl #(
    parameter int FLUSH_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rob_full,
    input  logic        id_stall_req,
    input  logic        mispredict_valid,
    input  logic [31:0] mispredict_target,
    input  logic        delayslot_done,
    input  logic        exc_valid,
    input  logic [31:0] exc_handler_pc,
    output logic [2:0]  stall,
    output logic        flush,
    output logic        redirect_en,
    output logic [31:0] redirect_pc
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    // state   | meaning
    // RUN     | normal operation, stall follows rob_full / id_stall_req
    // WAIT_DS | mispredict latched, waiting for the delay slot to leave IDROB
    // FLUSH   | flush asserted while the hold counter runs down
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_DS = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        first_q, first_d;
    logic        enter_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            hold_q        <= 4'd0;
            addr_q        <= 32'd0;
            redirect_pc_q <= 32'd0;
            first_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            addr_q        <= addr_d;
            redirect_pc_q <= redirect_pc_d;
            first_q       <= first_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        addr_d        = addr_q;
        redirect_pc_d = redirect_pc_q;
        first_d       = 1'b0;
        enter_flush   = 1'b0;
        case (state_q)
            RUN: begin
                if (exc_valid) begin
                    addr_d      = exc_handler_pc;
                    enter_flush = 1'b1;
                end else if (mispredict_valid) begin
                    addr_d = mispredict_target;
                    if (delayslot_done) enter_flush = 1'b1;
                    else                state_d     = WAIT_DS;
                end
            end
            WAIT_DS: begin
                if (exc_valid) begin
                    addr_d      = exc_handler_pc;
                    enter_flush = 1'b1;
                end else if (delayslot_done) begin
                    enter_flush = 1'b1;
                end
            end
            FLUSH: begin
                if (exc_valid) begin
                    addr_d      = exc_handler_pc;
                    enter_flush = 1'b1;
                end else if (hold_q <= 4'd1) begin
                    state_d = RUN;
                    hold_d  = 4'd0;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
        // redirect_pc only moves on a flush entry so it holds while redirect_en is low
        if (enter_flush) begin
            state_d       = FLUSH;
            hold_d        = 4'(FLUSH_HOLD);
            first_d       = 1'b1;
            redirect_pc_d = addr_d;
        end
    end

    always_comb begin
        flush       = (state_q == FLUSH);
        redirect_en = first_q;
        redirect_pc = redirect_pc_q;
        stall       = 3'b000;
        if (rst && state_q != FLUSH) begin
            if (rob_full)          stall = 3'b111;
            else if (id_stall_req) stall = 3'b011;
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (stall != 3'b000 && stall_cycles != 32'hffffffff)
                stall_cycles <= stall_cycles + 32'd1;
            if (enter_flush && flush_events != 32'hffffffff)
                flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_HOLD, default 1 (range 1..15): the number of consecutive cycles that flush stays asserted per flush event.
REQ-002 The block SHALL have port clk, input, 1: clock.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-004 The block SHALL have port rob_full, input, 1: ROB/reservation station cannot accept; front end holds.
REQ-005 The block SHALL have port id_stall_req, input, 1: ID cannot complete this cycle (operand not ready).
REQ-006 The block SHALL have port mispredict_valid, input, 1: branch misprediction detected at commit.
REQ-007 The block SHALL have port mispredict_target, input, 32: correct branch target address.
REQ-008 The block SHALL have port delayslot_done, input, 1: the delay slot of the pending branch has left IDROB.
REQ-009 The block SHALL have port exc_valid, input, 1: exception committed.
REQ-010 The block SHALL have port exc_handler_pc, input, 32: exception vector address.
REQ-011 The block SHALL have port stall, output, 3: [0] PC/IF hold, [1] IFID hold, [2] IDROB hold (drives stall_current_stage/stall_next_stage of IDROB).
REQ-012 The block SHALL have port flush, output, 1: clear IFID, IDROB, ROB.
REQ-013 The block SHALL have port redirect_en, output, 1: load redirect_pc into PC.
REQ-014 The block SHALL have port redirect_pc, output, 32: refetch address.

Function
REQ-015 The FSM SHALL have states RUN, WAIT_DS, FLUSH; the next state SHALL be registered on posedge clk.
REQ-016 In RUN or WAIT_DS, exc_valid SHALL latch exc_handler_pc, enter FLUSH, and load the hold counter with FLUSH_HOLD.
REQ-017 In RUN, mispredict_valid with exc_valid low SHALL latch mispredict_target: delayslot_done=1 in the same cycle -> FLUSH; otherwise -> WAIT_DS.
REQ-018 In WAIT_DS, delayslot_done=1 SHALL go to FLUSH with the latched target; further mispredict_valid pulses SHALL be ignored.
REQ-019 In FLUSH, flush=1 for exactly FLUSH_HOLD cycles; redirect_en=1 only in the first FLUSH cycle, with redirect_pc equal to the latched address; the FSM then returns to RUN.
REQ-020 exc_valid in FLUSH SHALL relatch the address and restart the FLUSH sequence, including a new redirect_en cycle; mispredict_valid in FLUSH SHALL be ignored.
REQ-021 Priority SHALL be exception > mispredict > stall.
REQ-022 stall SHALL be combinational from the inputs in RUN/WAIT_DS: rob_full -> 3'b111; id_stall_req only -> 3'b011; both -> 3'b111; neither -> 3'b000.
REQ-023 stall SHALL be 3'b000 while flush=1.
REQ-024 Flush/redirect latency SHALL be exactly one cycle after the triggering input (exc_valid, or mispredict_valid/delayslot_done).
REQ-025 redirect_pc SHALL hold its value when redirect_en=0.

Reset
REQ-026 When rst=0 at posedge clk: state=RUN, hold counter=0, latched address=0, flush=0, redirect_en=0, redirect_pc=0.
REQ-027 stall SHALL be forced to 3'b000 while rst=0.
REQ-028 Reset asserted mid-FLUSH or mid-WAIT_DS SHALL abort the sequence with no further redirect_en.

Configuration
REQ-029 With PIPELINE_CTRL_PERF_EN defined, the block SHALL add output stall_cycles (32) counting cycles with stall!=0, and output flush_events (32) counting FLUSH entries.
REQ-030 stall_cycles and flush_events SHALL saturate at 32'hffffffff and reset to 0.
REQ-031 Without PIPELINE_CTRL_PERF_EN, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-032 Case 1: rob_full=1 for 3 cycles -> stall=3'b111 in those cycles; id_stall_req=1 alone -> 3'b011.
REQ-033 Case 2: exc_valid with exc_handler_pc=32'hbfc00380 -> next cycle flush=1, redirect_en=1, redirect_pc=32'hbfc00380; flush deasserts after FLUSH_HOLD cycles.
REQ-034 Case 3: mispredict_valid with target 32'hbfc00040, delayslot_done=0; delayslot_done pulse 2 cycles later -> flush/redirect to 32'hbfc00040 the cycle after the pulse, none before.
REQ-035 Case 4: in WAIT_DS, exc_valid and delayslot_done asserted together -> redirect_pc = exc address, not the branch target.
REQ-036 Case 5: FLUSH_HOLD=3, exc_valid again in the 2nd FLUSH cycle with 32'hbfc00200 -> new redirect_en with 32'hbfc00200, then 3 more flush cycles; rob_full during flush -> stall=0.
REQ-037 Case 6: rst=0 during FLUSH -> all outputs 0 next cycle; with PIPELINE_CTRL_PERF_EN, counters read 0.
